// File: rtl/period_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : period_meter_if
// Description : Bundles the signal under measurement, the expected period and
//               the measurement results of period_meter into one interface.
//                 signal_in        - signal whose rising-edge spacing is timed
//                 period_in        - expected period in clk_in cycles
//                 period_out       - last measured period
//                 period_valid_out - one-cycle pulse when period_out updates
//                 match_out        - last measurement within tolerance
//                 locked_out       - measurement seen since reset/timeout
//                 timeout_out      - no edge seen for the timeout interval
//               master : side that drives the signal and reads results
//               slave  : the period meter itself
//               WIDTH must equal the WIDTH of the attached period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
interface period_meter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             signal_in;
    logic [WIDTH-1:0] period_in;
    logic [WIDTH-1:0] period_out;
    logic             period_valid_out;
    logic             match_out;
    logic             locked_out;
    logic             timeout_out;

    modport master (
        output signal_in,
        output period_in,
        input  period_out,
        input  period_valid_out,
        input  match_out,
        input  locked_out,
        input  timeout_out
    );

    modport slave (
        input  signal_in,
        input  period_in,
        output period_out,
        output period_valid_out,
        output match_out,
        output locked_out,
        output timeout_out
    );
endinterface
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module      : period_meter
// Description : Measures the spacing, in clk_in cycles, between consecutive
//               rising edges of bus.signal_in and compares it with the
//               expected period bus.period_in.
//               Ports:
//                 clk_in - system clock, all logic on its rising edge
//                 rst_in - asynchronous active-low reset; deassertion must be
//                          synchronised to clk_in by the surrounding system
//                 bus    - period_meter_if.slave (signal, expected period and
//                          measurement results)
//               Parameters:
//                 WIDTH          - width of period / count values
//                 TIMEOUT_CYCLES - cycles without an edge before loss of
//                                  signal is declared (2 .. 2**WIDTH-1)
//                 TOLERANCE      - largest |measured - expected| still
//                                  reported as a match
//               Build option:
//                 PERIOD_METER_SYNC_EN - when defined, signal_in first passes
//                                  a two-flop synchronizer and may be
//                                  asynchronous to clk_in (+2 cycles latency).
// Revision    : 1.0 - initial release
// ============================================================================
module period_meter #(
    parameter int unsigned      WIDTH          = 32,
    parameter logic [WIDTH-1:0] TIMEOUT_CYCLES = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] TOLERANCE      = '0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    period_meter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_TIMEOUT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_CNT_MAX = {WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic w_sig_src;

`ifdef PERIOD_METER_SYNC_EN
    // Two-flop synchronizer for an asynchronous signal_in.
    logic [1:0] sync_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.signal_in};
        end
    end

    assign w_sig_src = sync_q[1];
`else
    assign w_sig_src = bus.signal_in;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,        state_d;
    logic             sig_q;
    logic             sig_prev_q;
    logic [WIDTH-1:0] cnt_q,          cnt_d;
    logic [WIDTH-1:0] period_q,       period_d;
    logic             period_valid_q, period_valid_d;
    logic             match_q,        match_d;
    logic             locked_q,       locked_d;
    logic             timeout_q,      timeout_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= S_IDLE;
            sig_q          <= 1'b0;
            sig_prev_q     <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            match_q        <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sig_q          <= w_sig_src;
            sig_prev_q     <= sig_q;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            match_q        <= match_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic             w_edge;
    logic [WIDTH-1:0] w_diff;
    logic             w_within;
    logic [WIDTH-1:0] w_cnt_inc;

    assign w_edge = sig_q & ~sig_prev_q;

    // Subtract the smaller from the larger so the magnitude never wraps.
    assign w_diff = (cnt_q >= bus.period_in) ? (cnt_q - bus.period_in)
                                             : (bus.period_in - cnt_q);
    assign w_within = (w_diff <= TOLERANCE);

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : (cnt_q + c_CNT_ONE);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        match_d        = match_q;
        locked_d       = locked_q;
        timeout_d      = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                // First edge only starts timing; there is no interval yet.
                if (w_edge) begin
                    state_d = S_MEASURE;
                    cnt_d   = c_CNT_ONE;
                end
            end

            S_MEASURE: begin
                // An edge takes priority over the timeout check, so an edge
                // exactly TIMEOUT_CYCLES after the previous one is measured.
                if (w_edge) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    match_d        = w_within;
                    locked_d       = 1'b1;
                    cnt_d          = c_CNT_ONE;
                end else if (cnt_q == TIMEOUT_CYCLES) begin
                    state_d   = S_TIMEOUT;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = 1'b0;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end

            S_TIMEOUT: begin
                // The edge ending a loss of signal restarts timing only.
                if (w_edge) begin
                    state_d   = S_MEASURE;
                    cnt_d     = c_CNT_ONE;
                    timeout_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.period_out       = period_q;
    assign bus.period_valid_out = period_valid_q;
    assign bus.match_out        = match_q;
    assign bus.locked_out       = locked_q;
    assign bus.timeout_out      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_period_meter
// Description : Self-checking bench for period_meter. Two meters share one
//               stimulus stream: meter 0 with TIMEOUT_CYCLES 100 / TOLERANCE 0
//               and meter 1 with TIMEOUT_CYCLES 20 / TOLERANCE 2. Expected
//               measurements are queued when rising edges are driven and
//               compared when period_valid_out pulses; timeout_out is checked
//               every cycle against the time since the last edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_period_meter;

    localparam int unsigned      WIDTH = 32;
    localparam logic [WIDTH-1:0] T0    = 100;
    localparam logic [WIDTH-1:0] T1    = 20;
    localparam logic [WIDTH-1:0] TOL0  = 0;
    localparam logic [WIDTH-1:0] TOL1  = 2;
`ifdef PERIOD_METER_SYNC_EN
    localparam longint LAT = 4;
`else
    localparam longint LAT = 2;
`endif

    typedef struct {
        longint period;
        bit     mt;
        longint rise;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             sig   = 1'b0;
    logic [WIDTH-1:0] pin   = 10;
    longint           cyc   = 0;

    int n_checks = 0;
    int n_errors = 0;

    exp_t   q0[$];
    exp_t   q1[$];
    longint rq[$];
    longint landed      = 0;
    bit     have_landed = 1'b0;
    longint prev_rise   = 0;
    bit     have_prev   = 1'b0;
    logic   last_v      = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    period_meter_if #(.WIDTH(WIDTH)) bus0 ();
    period_meter_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus0.signal_in = sig;
    assign bus0.period_in = pin;
    assign bus1.signal_in = sig;
    assign bus1.period_in = pin;

    period_meter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(T0), .TOLERANCE(TOL0)) u_dut0 (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus0)
    );

    period_meter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(T1), .TOLERANCE(TOL1)) u_dut1 (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus1)
    );

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic longint absdiff(input longint a, input longint b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Called when a rising edge is driven: queue what each meter must report.
    task automatic record_rise();
        longint c;
        longint n;
        c = cyc;
        rq.push_back(c);
        if (have_prev) begin
            n = c - prev_rise;
            if (n <= longint'(T0))
                q0.push_back('{period: n, mt: absdiff(n, longint'(pin)) <= longint'(TOL0), rise: c});
            if (n <= longint'(T1))
                q1.push_back('{period: n, mt: absdiff(n, longint'(pin)) <= longint'(TOL1), rise: c});
        end
        prev_rise = c;
        have_prev = 1'b1;
    endtask

    task automatic flush_model();
        q0.delete();
        q1.delete();
        rq.delete();
        have_prev   = 1'b0;
        have_landed = 1'b0;
    endtask

    task automatic step(input logic v);
        if (v && !last_v) record_rise();
        sig    = v;
        last_v = v;
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int per, input int high, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++)
                step(i < high);
    endtask

    // Let in-flight measurements sample the old expected period first.
    task automatic set_pin(input logic [WIDTH-1:0] v);
        repeat (int'(LAT) + 2) step(1'b0);
        pin = v;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_period0"},  longint'(bus0.period_out),       0);
        check_eq({tag, "_valid0"},   longint'(bus0.period_valid_out), 0);
        check_eq({tag, "_match0"},   longint'(bus0.match_out),        0);
        check_eq({tag, "_locked0"},  longint'(bus0.locked_out),       0);
        check_eq({tag, "_timeout0"}, longint'(bus0.timeout_out),      0);
        check_eq({tag, "_period1"},  longint'(bus1.period_out),       0);
        check_eq({tag, "_valid1"},   longint'(bus1.period_valid_out), 0);
        check_eq({tag, "_match1"},   longint'(bus1.match_out),        0);
        check_eq({tag, "_locked1"},  longint'(bus1.locked_out),       0);
        check_eq({tag, "_timeout1"}, longint'(bus1.timeout_out),      0);
    endtask

    task automatic mon_dut(input int k, input logic v, input logic [WIDTH-1:0] p,
                           input logic m, input logic lk);
        exp_t e;
        bit   empty;
        if (!v) return;
        empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            check_eq($sformatf("spurious_valid%0d", k), longint'(v), 0);
            return;
        end
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check_eq($sformatf("period%0d", k),  longint'(p),  e.period);
        check_eq($sformatf("match%0d", k),   longint'(m),  longint'(e.mt));
        check_eq($sformatf("locked%0d", k),  longint'(lk), 1);
        check_eq($sformatf("latency%0d", k), cyc - e.rise, LAT);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_dut(0, bus0.period_valid_out, bus0.period_out, bus0.match_out, bus0.locked_out);
            mon_dut(1, bus1.period_valid_out, bus1.period_out, bus1.match_out, bus1.locked_out);
            while (rq.size() > 0 && (cyc - rq[0]) >= LAT) begin
                landed      = rq.pop_front();
                have_landed = 1'b1;
            end
            check_eq("timeout0", longint'(bus0.timeout_out),
                     longint'(have_landed && ((cyc - landed) >= longint'(T0) + LAT)));
            check_eq("timeout1", longint'(bus1.timeout_out),
                     longint'(have_landed && ((cyc - landed) >= longint'(T1) + LAT)));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Period 10 matching the expected value.
        wave(10, 5, 6);
        // Period 12 and 13 against an expected 10.
        wave(12, 6, 4);
        wave(13, 6, 4);

        // Loss of signal and recovery.
        wave(10, 5, 3);
        repeat (115) step(1'b0);
        check_eq("lost_timeout0", longint'(bus0.timeout_out), 1);
        check_eq("lost_locked0",  longint'(bus0.locked_out),  0);
        check_eq("lost_match0",   longint'(bus0.match_out),   0);
        check_eq("lost_period0",  longint'(bus0.period_out),  10);
        check_eq("lost_timeout1", longint'(bus1.timeout_out), 1);
        check_eq("lost_locked1",  longint'(bus1.locked_out),  0);
        check_eq("lost_period1",  longint'(bus1.period_out),  10);
        wave(10, 5, 3);

        // Spacing at and just past meter 1's timeout.
        set_pin(20);
        wave(20, 10, 4);
        wave(21, 10, 4);

        // Reset in the middle of a period.
        set_pin(10);
        wave(10, 5, 2);
        repeat (5) step(1'b1);
        repeat (2) step(1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        flush_model();
        @(posedge clk);
        #1;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        wave(10, 5, 3);

        // Minimum period.
        set_pin(2);
        wave(2, 1, 8);
        repeat (int'(LAT) + 3) step(1'b0);

        check_eq("q0_drained", longint'(q0.size()), 0);
        check_eq("q1_drained", longint'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/period_meter.md
# period_meter

Measures the period, in clk_in cycles, of a periodic digital signal by timing the spacing between consecutive rising edges. It is the receive side of the team's period-based counter and tone generators: it recovers the period a counter wraps at and reports whether it matches an expected value. Feeds status logic and debug readout in the same clock domain.

## Interface

- WIDTH, 32, width of period, count and expected-period values
- TIMEOUT_CYCLES, 2**WIDTH-1, cycles without an edge before declaring loss of signal; valid range 2..2**WIDTH-1
- TOLERANCE, 0, maximum |measured - expected| still reported as a match

- clk_in  input  1  system clock; all logic on rising edge
- rst_in  input  1  asynchronous, active-low reset
- signal_in  input  1  signal under measurement
- period_in  input  WIDTH  expected period in cycles; sampled when a measurement completes
- period_out  output  WIDTH  last measured period
- period_valid_out  output  1  one-cycle pulse when period_out updates
- match_out  output  1  last measurement within TOLERANCE of period_in
- locked_out  output  1  at least one measurement since last reset/timeout
- timeout_out  output  1  no edge for TIMEOUT_CYCLES

## Operation

- Input stage: signal_in registered into sig_q; previous value kept in sig_prev. Edge event e = sig_q & ~sig_prev.
- cnt: WIDTH-bit cycles-since-last-edge register; saturates at 2**WIDTH-1, never wraps.
- States: IDLE, MEASURE, TIMEOUT. Reset enters IDLE.
- IDLE: wait for e; on e -> MEASURE, cnt <= 1. No measurement emitted.
- MEASURE, on e: period_out <= cnt; period_valid_out <= 1; match_out <= (|cnt - period_in| <= TOLERANCE), unsigned difference computed without overflow; locked_out <= 1; cnt <= 1.
- MEASURE, no e: if cnt == TIMEOUT_CYCLES -> TIMEOUT; timeout_out <= 1; locked_out <= 0; match_out <= 0; period_out holds. Else cnt <= cnt + 1.
- Edge and cnt == TIMEOUT_CYCLES in same cycle: edge wins; measurement of TIMEOUT_CYCLES emitted, no timeout.
- TIMEOUT: on e -> MEASURE, cnt <= 1, timeout_out <= 0. First edge after timeout emits no measurement.
- Edges N cycles apart yield period_out = N. N = 1 is not achievable (edges need a low cycle); minimum is 2.
- period_in changes affect only the next measurement.

## Timing

- Reset values: period_out 0, period_valid_out 0, match_out 0, locked_out 0, timeout_out 0, cnt 0, sig_q 0, sig_prev 0, state IDLE.
- Reset is asynchronous on assertion; any in-progress measurement is discarded; deassertion is synchronous to clk_in at the design's top level.
- Latency without sync stage: signal_in rising sampled at edge k -> e in cycle k+1 -> period_valid_out high in cycle k+2.
- period_valid_out is exactly one cycle wide; consecutive pulses at least 2 cycles apart.
- period_out, match_out, locked_out update in the same cycle as period_valid_out.
- timeout_out asserts the cycle after the cycle where cnt == TIMEOUT_CYCLES with no edge; i.e. TIMEOUT_CYCLES+1 cycles after the last edge event.

## Configuration

- PERIOD_METER_SYNC_EN defined: signal_in passes through a two-flop synchronizer before sig_q; signal_in may be asynchronous; all signal-to-output latencies increase by 2 cycles; measured periods unchanged.
- Undefined: no synchronizer; signal_in must be synchronous to clk_in.

## Test plan

- Square wave period 10 (5 high / 5 low), period_in 10, TOLERANCE 0 -> first edge no pulse; each later edge period_valid_out pulse with period_out 10, match_out 1, locked_out 1.
- Switch wave to period 12, period_in 10 -> period_out 12, match_out 0; rerun with TOLERANCE 2 -> match_out 1; with period 13 -> match_out 0.
- TIMEOUT_CYCLES 100, period 10 then hold signal_in low -> timeout_out 1 exactly 101 cycles after last edge event, locked_out 0, match_out 0, period_out stays 10; resume toggling -> first edge clears timeout_out without pulse, second edge gives period_out 10.
- TIMEOUT_CYCLES 20, edges exactly 20 cycles apart -> period_out 20 every edge, timeout_out never asserts; spacing 21 -> timeout_out asserts, no period_valid_out.
- Assert rst_in low mid-period -> all outputs 0 immediately; after release first edge emits nothing, second edge gives correct period.
- Minimum period 2 (alternating 1/0) -> period_out 2 on every edge, pulses every 2 cycles; repeat with PERIOD_METER_SYNC_EN defined -> same values, 2 cycles later.
